sevenseg_decode: RTL and testbench
==================================

SEVENSEG_DECODE -- requirements
Module: sevenseg_decode

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, meaning consecutive identical synchronised samples needed to qualify a pattern (legal 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a, b, c, d, e, f, g  input  1 each  segment lines, active-low (0 = lit), asynchronous to clk.
REQ-005 digit  output  4  decoded hex value of the last qualified pattern.
REQ-006 blank  output  1  last qualified pattern had all segments unlit.
REQ-007 err  output  1  last qualified pattern matched no table entry and was not blank.
REQ-008 valid  output  1  digit/blank/err hold a result not yet accepted.
REQ-009 ready  input  1  consumer accepts the result when valid and ready are both 1 on a clock edge.
REQ-010 overrun  output  1  sticky; a qualified result was dropped.
REQ-011 overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-012 Each segment line SHALL pass a 2-flop synchroniser; lit vector L = ~{a,b,c,d,e,f,g} after synchronisation, with a as the MSB.
REQ-013 Decode SHALL map L to digit: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47 (hex of L).
REQ-014 L = 00 SHALL give blank=1, err=0, digit=0; any other unlisted L SHALL give err=1, blank=0, digit=0.
REQ-015 FSM states: IDLE, SETTLE, REPORT.
REQ-016 IDLE: when L differs from the last reported pattern, or no pattern has been reported since reset, SHALL go to SETTLE with stable counter = 1 and candidate = L.
REQ-017 SETTLE: when L equals candidate, increment the counter; when the counter reaches STABLE_CYCLES, qualify the candidate and go to REPORT; when L differs, reload candidate = L, reset the counter to 1, and remain in SETTLE.
REQ-018 Qualification when valid=0, or when valid=1 and ready=1 in the same cycle, SHALL load digit/blank/err, set valid=1 on the next edge, and record candidate as the last reported pattern.
REQ-019 Qualification when valid=1 and ready=0 SHALL drop the new result, set overrun=1, and still record candidate as the last reported pattern.
REQ-020 REPORT SHALL return to IDLE on the next cycle; detection continues while valid is pending.
REQ-021 valid SHALL fall on the edge where valid=1 and ready=1, unless a simultaneous qualification reloads it (REQ-018).
REQ-022 digit/blank/err SHALL hold stable while valid=1.
REQ-023 A return to the same pattern after a glitch shorter than STABLE_CYCLES SHALL NOT be reported again.
REQ-024 overrun_clr=1 SHALL clear overrun; a simultaneous set SHALL take priority over the clear.
REQ-025 Latency from the input change to valid rising SHALL be 2 (sync) + STABLE_CYCLES + 1 cycles, with ready held high.

Reset
REQ-026 rst=1 SHALL immediately force the FSM to IDLE and set digit=0, blank=0, err=0, valid=0, overrun=0, counter=0, synchronisers=all 1 (unlit), and the "reported" flag cleared.
REQ-027 rst asserted mid-SETTLE or while valid=1 SHALL discard the candidate and the pending result; after release, the first stable pattern is reported even if identical to the pre-reset pattern.

Verification
REQ-028 With STABLE_CYCLES=16 and ready=1, drive a..g=1,0,0,1,1,1,1 from reset -> valid rises 19 cycles after the change, digit=1, blank=0, err=0.
REQ-029 Drive a 5-cycle pulse of 0000000 (L=7F) between steady 1,0,0,1,1,1,1 patterns -> no new valid, digit remains 1.
REQ-030 Drive all lines 1 -> blank=1, digit=0; drive L=01 (g only lit) -> err=1, digit=0.
REQ-031 Hold ready=0 and qualify "2" (L=6D) then "3" (L=79) -> digit stays 2, overrun=1; pulse ready -> valid=0; pulse overrun_clr -> overrun=0.
REQ-032 Assert rst for 1 cycle during SETTLE of "8", then hold "8" -> valid after full latency, digit=8.
REQ-033 valid=1, ready=1 on the same edge as qualification of "A" (L=77) -> valid stays 1, digit=A, overrun=0.

Source files
------------

// File: rtl/sevenseg_decode_if.sv
// rtl/sevenseg_decode_if.sv - result stream between the seven-segment decoder and its consumer
// Ports (signals carried):
//    digit  [3:0]  decoded hex value of the last qualified pattern
//    blank         last qualified pattern had every segment unlit
//    err           last qualified pattern was neither blank nor a table entry
//    valid         digit/blank/err hold a result not yet accepted
//    ready         consumer accepts the result on an edge with valid=1
// Modports: master (decoder side), slave (consumer side).

interface sevenseg_decode_if;
   logic [3:0] digit;
   logic       blank;
   logic       err;
   logic       valid;
   logic       ready;

   modport master (
      output digit,
      output blank,
      output err,
      output valid,
      input  ready
   );

   modport slave (
      input  digit,
      input  blank,
      input  err,
      input  valid,
      output ready
   );
endinterface

// File: rtl/sevenseg_decode.sv
// rtl/sevenseg_decode.sv - debounced seven-segment pattern to hex digit decoder
// Parameter:
//    STABLE_CYCLES  consecutive identical synchronised samples needed to qualify (2..255)
// Ports:
//    clk            sole clock, rising edge
//    rst            asynchronous, active-high reset
//    a..g           segment lines, active-low, asynchronous to clk
//    res            result stream (master modport): digit, blank, err, valid, ready
//    overrun        sticky flag, a qualified result was dropped
//    overrun_clr    synchronous clear of overrun (a simultaneous set wins)

module sevenseg_decode #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      a,
   input  logic                      b,
   input  logic                      c,
   input  logic                      d,
   input  logic                      e,
   input  logic                      f,
   input  logic                      g,
   sevenseg_decode_if.master         res,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

   state_t     state, state_nxt;
   logic [6:0] sync1, sync2;
   logic [6:0] lit;
   logic [6:0] cand, cand_nxt;
   logic [6:0] last;
   logic [7:0] cnt, cnt_nxt;
   logic       reported;
   logic       qualify;
   logic       load;

   logic [3:0] dec_digit;
   logic       dec_blank;
   logic       dec_err;

   logic [3:0] digit_q;
   logic       blank_q;
   logic       err_q;
   logic       valid_q;

   // Two-flop synchroniser; resets to all-unlit so the first pattern after
   // reset is seen as a genuine change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= {a, b, c, d, e, f, g};
         sync2 <= sync1;
      end
   end

   // Active-high lit vector, segment a in the MSB.
   assign lit = ~sync2;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cand_nxt  = cand;
      qualify   = 1'b0;
      case (state)
         IDLE: begin
            if (!reported || (lit != last)) begin
               state_nxt = SETTLE;
               cnt_nxt   = 8'd1;
               cand_nxt  = lit;
            end
         end
         SETTLE: begin
            if (cnt == CNT_MAX) begin
               qualify   = 1'b1;
               state_nxt = REPORT;
            end else if (lit == cand) begin
               cnt_nxt = cnt + 8'd1;
            end else if (reported && (lit == last)) begin
               // Short glitch that fell back to the already reported
               // pattern: abandon it without reporting anything.
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
            end else begin
               cand_nxt = lit;
               cnt_nxt  = 8'd1;
            end
         end
         REPORT: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 8'd0;
         cand  <= 7'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cand  <= cand_nxt;
      end
   end

   always_comb begin
      dec_digit = 4'h0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (cand)
         7'h7E: dec_digit = 4'h0;
         7'h30: dec_digit = 4'h1;
         7'h6D: dec_digit = 4'h2;
         7'h79: dec_digit = 4'h3;
         7'h33: dec_digit = 4'h4;
         7'h5B: dec_digit = 4'h5;
         7'h5F: dec_digit = 4'h6;
         7'h70: dec_digit = 4'h7;
         7'h7F: dec_digit = 4'h8;
         7'h7B: dec_digit = 4'h9;
         7'h77: dec_digit = 4'hA;
         7'h1F: dec_digit = 4'hB;
         7'h4E: dec_digit = 4'hC;
         7'h3D: dec_digit = 4'hD;
         7'h4F: dec_digit = 4'hE;
         7'h47: dec_digit = 4'hF;
         7'h00: dec_blank = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   // A qualified result is only taken when the output slot is free or is
   // being emptied on this very edge; otherwise it is dropped as overrun.
   assign load = qualify && (!valid_q || res.ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_q  <= 4'h0;
         blank_q  <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         overrun  <= 1'b0;
         last     <= 7'd0;
         reported <= 1'b0;
      end else begin
         if (load) begin
            digit_q <= dec_digit;
            blank_q <= dec_blank;
            err_q   <= dec_err;
            valid_q <= 1'b1;
         end else if (valid_q && res.ready) begin
            valid_q <= 1'b0;
         end

         if (qualify) begin
            last     <= cand;
            reported <= 1'b1;
         end

         if (qualify && valid_q && !res.ready) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   assign res.digit = digit_q;
   assign res.blank = blank_q;
   assign res.err   = err_q;
   assign res.valid = valid_q;

endmodule

// File: tb/tb_sevenseg_decode.sv
// tb/tb_sevenseg_decode.sv - directed self-checking bench for sevenseg_decode
// Ports: none (top-level bench); drives clk, rst, segment lines, ready and overrun_clr.

module tb_sevenseg_decode;

   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ERR   = 7'b1111110;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] seg = 7'b1111111;
   logic       overrun;
   logic       overrun_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   sevenseg_decode_if res_if ();

   sevenseg_decode #(.STABLE_CYCLES(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .a           (seg[6]),
      .b           (seg[5]),
      .c           (seg[4]),
      .d           (seg[3]),
      .e           (seg[2]),
      .f           (seg[1]),
      .g           (seg[0]),
      .res         (res_if.master),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (res_if.valid !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      check(tag, {31'd0, res_if.valid}, 32'd1);
   endtask

   // Called right after rst is released (#1 past an edge) with the pattern
   // already on the lines: valid must stay low for 18 edges and rise on the 19th.
   task automatic run_latency(input string tag, input logic [3:0] exp_digit);
      logic early;
      early = 1'b0;
      for (int i = 0; i < 18; i++) begin
         tick();
         if (res_if.valid === 1'b1) early = 1'b1;
      end
      check({tag, "_no_early_valid"}, {31'd0, early}, 32'd0);
      tick();
      check({tag, "_valid_at_19"}, {31'd0, res_if.valid}, 32'd1);
      check({tag, "_digit"}, {28'd0, res_if.digit}, {28'd0, exp_digit});
      check({tag, "_blank"}, {31'd0, res_if.blank}, 32'd0);
      check({tag, "_err"}, {31'd0, res_if.err}, 32'd0);
   endtask

   initial begin
      logic saw;
      res_if.ready = 1'b1;
      seg = SEG_1;
      #1;
      rst = 1'b1;
      #1;
      check("rst_valid", {31'd0, res_if.valid}, 32'd0);
      check("rst_digit", {28'd0, res_if.digit}, 32'd0);
      check("rst_blank", {31'd0, res_if.blank}, 32'd0);
      check("rst_err", {31'd0, res_if.err}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      tick();
      rst = 1'b0;

      // Digit 1 latency with ready high.
      run_latency("lat1", 4'h1);
      tick();
      check("lat1_consumed", {31'd0, res_if.valid}, 32'd0);

      // 5-cycle glitch to L=7F must not produce a new report.
      seg = SEG_8;
      repeat (5) tick();
      seg = SEG_1;
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (res_if.valid === 1'b1) saw = 1'b1;
      end
      check("glitch_no_valid", {31'd0, saw}, 32'd0);
      check("glitch_digit", {28'd0, res_if.digit}, 32'd1);

      // Blank pattern.
      seg = SEG_BLANK;
      wait_valid("blank_wait", 60);
      check("blank_blank", {31'd0, res_if.blank}, 32'd1);
      check("blank_digit", {28'd0, res_if.digit}, 32'd0);
      check("blank_err", {31'd0, res_if.err}, 32'd0);
      tick();

      // Only segment g lit: not a table entry.
      seg = SEG_ERR;
      wait_valid("err_wait", 60);
      check("err_err", {31'd0, res_if.err}, 32'd1);
      check("err_digit", {28'd0, res_if.digit}, 32'd0);
      check("err_blank", {31'd0, res_if.blank}, 32'd0);
      tick();

      // Overrun: "3" qualifies while "2" is still pending.
      res_if.ready = 1'b0;
      seg = SEG_2;
      wait_valid("ovr_wait2", 60);
      check("ovr_digit2", {28'd0, res_if.digit}, 32'd2);
      seg = SEG_3;
      repeat (25) tick();
      check("ovr_set", {31'd0, overrun}, 32'd1);
      check("ovr_digit_held", {28'd0, res_if.digit}, 32'd2);
      check("ovr_valid_held", {31'd0, res_if.valid}, 32'd1);
      res_if.ready = 1'b1;
      tick();
      res_if.ready = 1'b0;
      check("ovr_ready_pulse_valid", {31'd0, res_if.valid}, 32'd0);
      check("ovr_sticky", {31'd0, overrun}, 32'd1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("ovr_cleared", {31'd0, overrun}, 32'd0);

      // Reset in the middle of settling "8", then full latency again.
      res_if.ready = 1'b1;
      seg = SEG_8;
      repeat (8) tick();
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'd0, res_if.valid}, 32'd0);
      check("midrst_digit", {28'd0, res_if.digit}, 32'd0);
      res_if.ready = 1'b0;
      tick();
      rst = 1'b0;
      run_latency("lat8", 4'h8);

      // "A" qualifies on the same edge that "8" is accepted.
      seg = SEG_A;
      repeat (18) tick();
      check("simul_pre_valid", {31'd0, res_if.valid}, 32'd1);
      check("simul_pre_digit", {28'd0, res_if.digit}, 32'd8);
      res_if.ready = 1'b1;
      tick();
      check("simul_valid", {31'd0, res_if.valid}, 32'd1);
      check("simul_digit", {28'd0, res_if.digit}, 32'hA);
      check("simul_overrun", {31'd0, overrun}, 32'd0);
      tick();
      check("simul_consumed", {31'd0, res_if.valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
